regfile_wb_arbiter: RTL

Shares the single register-file write port between two writeback requesters. Requester A is the main pipeline WB stage. Requester B is the multi-cycle unit (mult/div, late loads). The block drives one-hot load enables and a shared data bus into the 32-entry register bank, whose entry 0 is the hardwired zero register. It also keeps a busy scoreboard of registers with pending multi-cycle results, so hazard logic can stall.

---
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the main pipeline
//   writeback (requester A) and the multi-cycle unit (requester B). It keeps
//   a busy scoreboard of registers whose multi-cycle results are still
//   outstanding.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   a_valid/a_addr/a_data     requester A write request
//   a_ready                   A accepted this cycle (combinational)
//   b_valid/b_addr/b_data     requester B write request
//   b_ready                   B accepted this cycle (combinational)
//   rsv_valid/rsv_addr        reserve a B destination at issue (marks busy)
//   wr_load/wr_addr/wr_data   registered one-hot write into the register bank
//   busy                      scoreboard, bit i = result for reg i pending
module regfile_wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [4:0]       a_addr,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [4:0]       b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             rsv_valid,
  input  logic [4:0]       rsv_addr,
  output logic [31:0]      wr_load,
  output logic [4:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [31:0]      busy
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic [31:0]      wr_load_q, wr_load_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [31:0]      busy_q, busy_d;

  logic grant_a, grant_b, xfer;
  logic [4:0]       sel_addr;
  logic [WIDTH-1:0] sel_data;

  // B wins when alone, or when it has been refused long enough.
  always_comb begin
    grant_b = b_valid && (!a_valid || (starve_q >= LIMIT));
    grant_a = a_valid && !grant_b;
  end

  // Nothing is acknowledged while reset is held.
  assign a_ready = grant_a && !rst;
  assign b_ready = grant_b && !rst;
  assign xfer    = a_ready || b_ready;

  assign sel_addr = b_ready ? b_addr : a_addr;
  assign sel_data = b_ready ? b_data : a_data;

  always_comb begin
    starve_d = starve_q;
    if (!b_valid || grant_b)  starve_d = '0;
    else if (starve_q < LIMIT) starve_d = starve_q + 1'b1;

    wr_load_d = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      // Writes to the zero register complete but never reach the bank.
      if (sel_addr != 5'd0) wr_load_d[sel_addr] = 1'b1;
    end

    // Clear first so a same-cycle reservation of the same register wins.
    busy_d = busy_q;
    if (b_ready && (b_addr != 5'd0))      busy_d[b_addr]   = 1'b0;
    if (rsv_valid && (rsv_addr != 5'd0))  busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      wr_load_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_load_q <= wr_load_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_load = wr_load_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule
